seven_seg_scan: RTL and testbench

- Downstream consumer of the binary-to-BCD converter: takes its four BCD digit outputs and drives the board's 4-digit, common-anode seven-segment display.
- Time-multiplexes the digits, decodes each digit to segments, blanks leading zeros and shows a dash for invalid BCD.
- Holds a shadow copy of the digits, latched on a load strobe, so the display never tears mid-scan.

---
 rtl/seven_seg_scan.sv | 111 +++++++++++
 tb/tb_seven_seg_scan.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// Four-digit common-anode seven-segment scanner. It latches BCD digits into a
// shadow register and time-multiplexes them with leading-zero blanking.
module seven_seg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] thousands,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [3:0] anode,
  output logic [6:0] segments,
  output logic [1:0] scan_pos
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] digit);
    case (digit)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = SEG_DASH;
    endcase
  endfunction

  logic [3:0][3:0] shadow;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic             wrap;

  logic             blank_th, blank_hu, blank_te;
  logic [3:0]       cur_digit;
  logic             cur_blank;
  logic [3:0]       anode_d;
  logic [6:0]       seg_d;

  assign wrap = (cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and process ordering cannot matter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= {thousands, hundreds, tens, ones};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (wrap) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Blanking cascades downward; a non-decimal code is never treated as zero.
  assign blank_th = BLANK_LZ && (shadow[3] == 4'd0);
  assign blank_hu = blank_th && (shadow[2] == 4'd0);
  assign blank_te = blank_hu && (shadow[1] == 4'd0);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cur_digit = shadow[0];
    cur_blank = 1'b0;
    anode_d   = 4'b1111;
    case (idx)
      2'd1: begin cur_digit = shadow[1]; cur_blank = blank_te; end
      2'd2: begin cur_digit = shadow[2]; cur_blank = blank_hu; end
      2'd3: begin cur_digit = shadow[3]; cur_blank = blank_th; end
      default: ;
    endcase
    if (!cur_blank) anode_d[idx] = 1'b0;
    seg_d = cur_blank ? SEG_OFF : decode(cur_digit);
  end

  // Registered outputs: one cycle behind idx, no input-to-output path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anode    <= 4'b1111;
      segments <= SEG_OFF;
      scan_pos <= 2'd0;
    end else begin
      anode    <= anode_d;
      segments <= seg_d;
      scan_pos <= idx;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: three instances (div 4 blanking, div 4 no blanking,
// div 1 blanking) share stimulus; a per-cycle scoreboard checks all three.
module tb_seven_seg_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [3:0] thousands = '0, hundreds = '0, tens = '0, ones = '0;

  logic [3:0] anode_a, anode_b, anode_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic [1:0] pos_a, pos_b, pos_c;

  always #5 clk = ~clk;

  seven_seg_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .rst(rst), .load(load), .thousands(thousands), .hundreds(hundreds),
    .tens(tens), .ones(ones), .anode(anode_a), .segments(seg_a), .scan_pos(pos_a));
  seven_seg_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .rst(rst), .load(load), .thousands(thousands), .hundreds(hundreds),
    .tens(tens), .ones(ones), .anode(anode_b), .segments(seg_b), .scan_pos(pos_b));
  seven_seg_scan #(.REFRESH_DIV(1), .BLANK_LZ(1'b1)) dut_c (
    .clk(clk), .rst(rst), .load(load), .thousands(thousands), .hundreds(hundreds),
    .tens(tens), .ones(ones), .anode(anode_c), .segments(seg_c), .scan_pos(pos_c));

  // Digits {thousands,hundreds,tens,ones}; seg[s] is the unblanked code for
  // slot s (0 = ones); mask bit s set = slot blanked when blanking is on.
  typedef struct packed {
    logic [15:0]     digits;
    logic [3:0][6:0] seg;
    logic [3:0]      mask;
  } vec_t;

  typedef struct packed {
    logic [12:0] a;
    logic [12:0] b;
    logic [12:0] c;
  } sb_t;

  localparam logic [12:0] OUT_OFF = {4'b1111, 7'b1111111, 2'd0};
  localparam int ZERO_VEC = 1;

  vec_t vecs [7];
  sb_t  sb_q [$];
  int   checks = 0;
  int   passed = 0;
  int   edge_n = 0;
  int   shown  = ZERO_VEC;

  task automatic check(input string name, input logic [12:0] actual, input logic [12:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("FAIL %s: got anode=%b seg=%b pos=%0d, expected anode=%b seg=%b pos=%0d",
                  name, actual[12:9], actual[8:2], actual[1:0],
                  expected[12:9], expected[8:2], expected[1:0]);
  endtask

  function automatic logic [12:0] exp_out(input vec_t v, input int slot, input bit blz);
    logic [3:0] an;
    if (blz && v.mask[slot]) return {4'b1111, 7'b1111111, 2'(slot)};
    an = 4'b1111;
    an[slot] = 1'b0;
    return {an, v.seg[slot], 2'(slot)};
  endfunction

  task automatic compare_pop(input string tag);
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "/div4_blz"},  {anode_a, seg_a, pos_a}, e.a);
    check({tag, "/div4_nblz"}, {anode_b, seg_b, pos_b}, e.b);
    check({tag, "/div1_blz"},  {anode_c, seg_c, pos_c}, e.c);
  endtask

  // One clock: push the expected post-edge outputs, drive, then compare.
  task automatic step(input bit do_load, input int vi, input string tag);
    sb_t e;
    int  n;
    n = edge_n + 1;
    e.a = exp_out(vecs[shown], ((n - 1) / 4) % 4, 1'b1);
    e.b = exp_out(vecs[shown], ((n - 1) / 4) % 4, 1'b0);
    e.c = exp_out(vecs[shown], (n - 1) % 4, 1'b1);
    sb_q.push_back(e);
    load = do_load;
    if (do_load) {thousands, hundreds, tens, ones} = vecs[vi].digits;
    else         {thousands, hundreds, tens, ones} = 16'($urandom);
    @(posedge clk);
    edge_n = n;
    if (do_load) shown = vi;
    @(negedge clk);
    load = 1'b0;
    compare_pop(tag);
  endtask

  task automatic expect_off(input string tag);
    sb_q.push_back('{a: OUT_OFF, b: OUT_OFF, c: OUT_OFF});
    compare_pop(tag);
  endtask

  // Reset asserted and released on falling edges, away from the active edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    expect_off("reset_async");
    @(negedge clk);
    rst = 1'b1;
    edge_n = 0;
    shown  = ZERO_VEC;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{digits: 16'h0255, seg: {7'b1000000, 7'b0100100, 7'b0010010, 7'b0010010}, mask: 4'b1000};
    vecs[1] = '{digits: 16'h0000, seg: {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, mask: 4'b1110};
    vecs[2] = '{digits: 16'h00C0, seg: {7'b1000000, 7'b1000000, 7'b0111111, 7'b1000000}, mask: 4'b1100};
    vecs[3] = '{digits: 16'h1234, seg: {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, mask: 4'b0000};
    vecs[4] = '{digits: 16'h0709, seg: {7'b1000000, 7'b1111000, 7'b1000000, 7'b0010000}, mask: 4'b1000};
    vecs[5] = '{digits: 16'hF008, seg: {7'b0111111, 7'b1000000, 7'b1000000, 7'b0000000}, mask: 4'b0000};
    vecs[6] = '{digits: 16'h006A, seg: {7'b1000000, 7'b1000000, 7'b0000010, 7'b0111111}, mask: 4'b1100};

    // Held in reset: loads and input changes must not reach the outputs.
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      load = 1'b1;
      {thousands, hundreds, tens, ones} = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      expect_off("reset_hold");
    end
    load = 1'b0;

    // Table: load once, then two full rotations with garbage on the inputs.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      step(1'b1, v, $sformatf("vec%0d_load", v));
      for (int k = 0; k < 32; k++) step(1'b0, 0, $sformatf("vec%0d_scan", v));
    end

    // Load on the same edge as the first counter wrap of the div-4 scanners.
    do_reset();
    step(1'b1, 0, "wrap_pre");
    step(1'b0, 0, "wrap_pre");
    step(1'b0, 0, "wrap_pre");
    step(1'b1, 3, "wrap_load");
    for (int k = 0; k < 12; k++) step(1'b0, 0, "wrap_post");

    // Reset mid-slot: div-1 scanner sits at idx 2, div-4 is mid-dwell.
    do_reset();
    step(1'b1, 4, "midrst_pre");
    step(1'b0, 0, "midrst_pre");
    rst = 1'b0;
    #1;
    expect_off("midrst_async");
    for (int k = 0; k < 2; k++) begin
      load = 1'b1;
      {thousands, hundreds, tens, ones} = 16'h1234;
      @(posedge clk);
      @(negedge clk);
      expect_off("midrst_hold");
    end
    load = 1'b0;
    rst = 1'b1;
    edge_n = 0;
    shown  = ZERO_VEC;
    for (int k = 0; k < 6; k++) step(1'b0, 0, "midrst_restart");
    step(1'b1, 4, "midrst_reload");
    for (int k = 0; k < 16; k++) step(1'b0, 0, "midrst_scan");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
